food_place_ctrl: RTL and testbench

- Sequences the random box generator to place food on the LED array.
- On game start or when the snake eats, pulses the generator's drive input and waits for the new coordinate.
- Range-checks the coordinate, then asks the snake body store whether that cell is occupied; out-of-range or occupied candidates are retried.
- Publishes one validated food position to the display and game logic.

---
 rtl/food_place_ctrl.sv | 134 +++++++++++++
 tb/tb_food_place_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/food_place_ctrl.sv
`timescale 1ns/1ps
// food_place_ctrl: sequences the random box generator to place validated food on the LED array
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, eat        new-game / snake-ate pulses that trigger a placement
//   drive             one-cycle pulse to the random box generator
//   box_x, box_y      candidate coordinate from the generator
//   occ_req           occupancy query strobe to the snake body store
//   occ_x, occ_y      coordinate under query
//   occ_hit           occupancy answer, valid one cycle after occ_req
//   food_x, food_y    placed food position, qualified by food_valid
//   busy              placement in progress
//   place_fail        one-cycle pulse when MAX_TRIES candidates were rejected
// Optional: define FOOD_EDGE_MARGIN_EN to keep food off the border cells.
module food_place_ctrl #(
    parameter int COLS      = 64,
    parameter int ROWS      = 32,
    parameter int GEN_LAT   = 2,
    parameter int MAX_TRIES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       eat,
    output logic       drive,
    input  logic [6:0] box_x,
    input  logic [4:0] box_y,
    output logic       occ_req,
    output logic [6:0] occ_x,
    output logic [4:0] occ_y,
    input  logic       occ_hit,
    output logic [6:0] food_x,
    output logic [4:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       place_fail
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, RESULT, RETRY} state_t;
    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d, tries_q, tries_d;
    logic [6:0] cand_x_q, cand_x_d, food_x_q, food_x_d;
    logic [4:0] cand_y_q, cand_y_d, food_y_q, food_y_d;
    logic       food_valid_q, food_valid_d, fail_q, fail_d;
    logic       in_range;
`ifdef FOOD_EDGE_MARGIN_EN
    assign in_range = int'(cand_x_q) > 0 && int'(cand_x_q) < COLS - 1 &&
                      int'(cand_y_q) > 0 && int'(cand_y_q) < ROWS - 1;
`else
    assign in_range = int'(cand_x_q) < COLS && int'(cand_y_q) < ROWS;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            tries_q      <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            tries_q      <= tries_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            fail_q       <= fail_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        tries_d      = tries_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        fail_d       = 1'b0;
        case (state_q)
            IDLE: if (start || (eat && food_valid_q)) begin
                state_d      = DRIVE;
                food_valid_d = 1'b0;
                tries_d      = '0;
            end
            DRIVE: begin
                wait_d  = 8'(GEN_LAT);
                state_d = WAIT;
            end
            WAIT: if (wait_q == '0) begin
                cand_x_d = box_x;
                cand_y_d = box_y;
                state_d  = CHECK;
            end else begin
                wait_d = wait_q - 8'd1;
            end
            CHECK: state_d = in_range ? RESULT : RETRY;
            RESULT: if (occ_hit) begin
                state_d = RETRY;
            end else begin
                food_x_d     = cand_x_q;
                food_y_d     = cand_y_q;
                food_valid_d = 1'b1;
                state_d      = IDLE;
            end
            RETRY: begin
                tries_d = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
                fail_d  = (tries_d == 8'(MAX_TRIES));
                state_d = fail_d ? IDLE : DRIVE;
            end
            default: state_d = IDLE;
        endcase
        // a new game aborts whatever placement is in flight
        if (start && state_q != IDLE) begin
            state_d      = DRIVE;
            tries_d      = '0;
            food_valid_d = 1'b0;
            fail_d       = 1'b0;
        end
    end
    assign drive      = (state_q == DRIVE);
    assign occ_req    = (state_q == CHECK) && in_range;
    assign occ_x      = cand_x_q;
    assign occ_y      = cand_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = (state_q != IDLE);
    assign place_fail = fail_q;
endmodule

// File: tb/tb_food_place_ctrl.sv
`timescale 1ns/1ps
// tb_food_place_ctrl: directed self-checking bench for food_place_ctrl
module tb_food_place_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, eat = 1'b0, occ_hit = 1'b0;
    logic [6:0] box_x = '0, occ_x, food_x;
    logic [4:0] box_y = '0, occ_y, food_y;
    logic       drive, occ_req, food_valid, busy, place_fail;
    int errors = 0, checks = 0;
    int gen_x[16], gen_y[16];
    int gen_n = 1, gi = 0, hit_n = 0, drives = 0, reqs = 0, fails = 0;
    logic hit_all = 1'b0;
    int last_ox = 0, last_oy = 0;

    food_place_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eat(eat), .drive(drive),
        .box_x(box_x), .box_y(box_y), .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
        .occ_hit(occ_hit), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .place_fail(place_fail)
    );

    always #5 clk = ~clk;

    // generator and snake-body-store responder
    initial begin
        forever begin
            @(negedge clk);
            if (drive) begin
                drives++;
                box_x = 7'(gen_x[gi]);
                box_y = 5'(gen_y[gi]);
                if (gi < gen_n - 1) gi++;
            end
            if (occ_req) begin
                reqs++;
                last_ox = int'(occ_x);
                last_oy = int'(occ_y);
                occ_hit = hit_all || (reqs <= hit_n);
            end
            if (place_fail) fails++;
        end
    end

    task automatic setup(input int n, input int hn, input logic ha);
        gen_n = n; gi = 0; hit_n = hn; hit_all = ha;
        drives = 0; reqs = 0; fails = 0; occ_hit = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic e);
        @(posedge clk); #1 start = s; eat = e;
        @(posedge clk); #1 start = 1'b0; eat = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        for (c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (c == 400) begin errors++; $display("FAIL %s_timeout: busy still 1 after 400 cycles, required 0", name); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({drive, occ_req, food_valid, busy, place_fail, food_x, food_y, occ_x, occ_y} !== '0) begin
            errors++; $display("FAIL reset_outputs: got drive=%b req=%b fv=%b busy=%b fail=%b, required all 0", drive, occ_req, food_valid, busy, place_fail);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic dr[7], rq[7], fv[7], bz[7];
        logic [6:0] ox;
        logic [4:0] oy;
        gen_x[0] = 10; gen_y[0] = 5;
        setup(1, 0, 1'b0);
        pulse(1'b1, 1'b0);
        ox = '0; oy = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            dr[c] = drive; rq[c] = occ_req; fv[c] = food_valid; bz[c] = busy;
            if (c == 4) begin ox = occ_x; oy = occ_y; end
        end
        checks++; if (dr[0] !== 1'b1) begin errors++; $display("FAIL basic_drive_pulse: got %b, required 1", dr[0]); end
        checks++; if (dr[1] !== 1'b0) begin errors++; $display("FAIL basic_drive_width: got %b, required 0", dr[1]); end
        checks++; if (rq[4] !== 1'b1 || ox !== 7'd10 || oy !== 5'd5) begin errors++; $display("FAIL basic_occ_req: got req=%b (%0d,%0d), required 1 (10,5)", rq[4], ox, oy); end
        checks++; if (fv[5] !== 1'b0 || bz[5] !== 1'b1) begin errors++; $display("FAIL basic_early: got fv=%b busy=%b, required 0 1", fv[5], bz[5]); end
        checks++; if (fv[6] !== 1'b1 || bz[6] !== 1'b0) begin errors++; $display("FAIL basic_latency: got fv=%b busy=%b, required 1 0", fv[6], bz[6]); end
        checks++; if (food_x !== 7'd10 || food_y !== 5'd5) begin errors++; $display("FAIL basic_food: got (%0d,%0d), required (10,5)", food_x, food_y); end
        checks++; if (drives !== 1 || reqs !== 1) begin errors++; $display("FAIL basic_counts: got drives=%0d reqs=%0d, required 1 1", drives, reqs); end
    endtask

    task automatic test_range_reject();
        gen_x[0] = 100; gen_y[0] = 5; gen_x[1] = 20; gen_y[1] = 7;
        setup(2, 0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("range");
        checks++; if (drives !== 2 || reqs !== 1) begin errors++; $display("FAIL range_counts: got drives=%0d reqs=%0d, required 2 1", drives, reqs); end
        checks++; if (food_valid !== 1'b1 || food_x !== 7'd20 || food_y !== 5'd7 || last_ox !== 20) begin errors++; $display("FAIL range_food: got fv=%b (%0d,%0d), required 1 (20,7)", food_valid, food_x, food_y); end
    endtask

    task automatic test_occupied();
        gen_x[0] = 7; gen_y[0] = 1; gen_x[1] = 8; gen_y[1] = 2;
        gen_x[2] = 9; gen_y[2] = 3; gen_x[3] = 3; gen_y[3] = 3;
        setup(4, 3, 1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("occupied");
        checks++; if (drives !== 4 || reqs !== 4) begin errors++; $display("FAIL occupied_counts: got drives=%0d reqs=%0d, required 4 4", drives, reqs); end
        checks++; if (food_valid !== 1'b1 || food_x !== 7'd3 || food_y !== 5'd3) begin errors++; $display("FAIL occupied_food: got fv=%b (%0d,%0d), required 1 (3,3)", food_valid, food_x, food_y); end
    endtask

    task automatic test_eat();
        gen_x[0] = 40; gen_y[0] = 20;
        setup(1, 0, 1'b0);
        pulse(1'b0, 1'b1);
        wait_idle("eat");
        checks++; if (drives !== 1 || food_valid !== 1'b1 || food_x !== 7'd40 || food_y !== 5'd20) begin errors++; $display("FAIL eat_place: got drives=%0d fv=%b (%0d,%0d), required 1 1 (40,20)", drives, food_valid, food_x, food_y); end
    endtask

    task automatic test_fail();
        gen_x[0] = 12; gen_y[0] = 12;
        setup(1, 0, 1'b1);
        pulse(1'b1, 1'b0);
        wait_idle("fail");
        checks++; if (drives !== 15 || reqs !== 15) begin errors++; $display("FAIL fail_counts: got drives=%0d reqs=%0d, required 15 15", drives, reqs); end
        checks++; if (fails !== 1) begin errors++; $display("FAIL fail_pulse: got %0d cycles, required 1", fails); end
        checks++; if (food_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fail_state: got fv=%b busy=%b, required 0 0", food_valid, busy); end
    endtask

    task automatic test_eat_ignored();
        logic seen;
        setup(1, 0, 1'b0);
        pulse(1'b0, 1'b1);
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen = seen | busy | drive; end
        checks++; if (seen !== 1'b0 || drives !== 0) begin errors++; $display("FAIL eat_no_food: got activity=%b drives=%0d, required 0 0", seen, drives); end
    endtask

    task automatic test_back_to_back();
        int nd, c;
        gen_x[0] = 30; gen_y[0] = 10; gen_x[1] = 31; gen_y[1] = 11; gen_x[2] = 32; gen_y[2] = 12;
        setup(3, 1, 1'b0);
        pulse(1'b1, 1'b0);
        nd = 0;
        for (c = 0; c < 100 && nd < 2; c++) begin
            if (drive) nd++;
            if (nd < 2) @(negedge clk);
        end
        checks++; if (nd !== 2) begin errors++; $display("FAIL restart_second_drive: got %0d drives, required 2", nd); end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; eat = 1'b1;
        @(negedge clk);
        checks++; if (dut.tries_q !== 8'd0 || drive !== 1'b1) begin errors++; $display("FAIL restart_cleared: got tries=%0d drive=%b, required 0 1", dut.tries_q, drive); end
        @(posedge clk); #1 eat = 1'b0;
        wait_idle("restart");
        checks++; if (drives !== 3 || reqs !== 2) begin errors++; $display("FAIL restart_counts: got drives=%0d reqs=%0d, required 3 2", drives, reqs); end
        checks++; if (food_valid !== 1'b1 || food_x !== 7'd32 || food_y !== 5'd12) begin errors++; $display("FAIL restart_food: got fv=%b (%0d,%0d), required 1 (32,12)", food_valid, food_x, food_y); end
    endtask

    task automatic test_reset_mid();
        int c;
        logic seen;
        gen_x[0] = 15; gen_y[0] = 6;
        setup(1, 0, 1'b0);
        pulse(1'b1, 1'b0);
        for (c = 0; c < 50 && !occ_req; c++) @(negedge clk);
        checks++; if (occ_req !== 1'b1) begin errors++; $display("FAIL rstmid_reach: got occ_req=%b, required 1", occ_req); end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({drive, occ_req, food_valid, busy, place_fail, food_x, food_y, occ_x, occ_y} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got fv=%b busy=%b food=(%0d,%0d), required all 0", food_valid, busy, food_x, food_y);
        end
        @(negedge clk); rst_n = 1'b1;
        setup(1, 0, 1'b0);
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen = seen | busy | drive | occ_req; end
        checks++; if (seen !== 1'b0 || dut.state_q !== 3'd0) begin errors++; $display("FAIL rstmid_idle: got activity=%b state=%0d, required 0 0", seen, dut.state_q); end
    endtask

    task automatic test_edge_margin();
        gen_x[0] = 0; gen_y[0] = 4; gen_x[1] = 5; gen_y[1] = 31; gen_x[2] = 5; gen_y[2] = 4;
        setup(3, 0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("margin");
`ifdef FOOD_EDGE_MARGIN_EN
        checks++; if (drives !== 3 || reqs !== 1 || food_x !== 7'd5 || food_y !== 5'd4) begin errors++; $display("FAIL margin_reject: got drives=%0d reqs=%0d (%0d,%0d), required 3 1 (5,4)", drives, reqs, food_x, food_y); end
`else
        checks++; if (drives !== 1 || reqs !== 1 || food_x !== 7'd0 || food_y !== 5'd4) begin errors++; $display("FAIL border_accept: got drives=%0d reqs=%0d (%0d,%0d), required 1 1 (0,4)", drives, reqs, food_x, food_y); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range_reject();
        test_occupied();
        test_eat();
        test_fail();
        test_eat_ignored();
        test_back_to_back();
        test_edge_margin();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
